// File: rtl/serial_out_sequencer.sv
// serial_out_sequencer: manual one-hot serial output mux plus an auto channel-scan engine.
// Optional SER_PARITY_EN appends one even-parity bit after each channel frame.
module serial_out_sequencer #(
    parameter int NUM_CH     = 8,
    parameter int FRAME_BITS = 12,
    parameter int CH_W       = $clog2(NUM_CH),
    parameter int BIT_W      = $clog2(FRAME_BITS + 1)
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] raw_serial_out,
    input  logic              wr_serial_out,
    input  logic [NUM_CH-1:0] load_cnt_ser,
    input  logic              auto_start,
    input  logic [NUM_CH-1:0] auto_ch_mask,
    output logic              serial_out,
    output logic              busy,
    output logic              frame_valid,
    output logic [CH_W-1:0]   active_ch,
    output logic              sel_err
);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SCAN, DONE, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
`endif

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    state_t              r_state;
    logic [NUM_CH-1:0]   r_sel;
    logic [NUM_CH-1:0]   r_mask;
    logic [BIT_W-1:0]    r_bit;
    logic [CH_W-1:0]     r_ch;
`ifdef SER_PARITY_EN
    logic                r_par;
`endif

    logic                w_multi;
    logic [CH_W-1:0]     w_sel_idx;
    logic [NUM_CH-1:0]   w_rem;

    function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] m);
        logic found;
        lowest_idx = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (m[i] && !found) begin
                lowest_idx = CH_W'(i);
                found      = 1'b1;
            end
        end
    endfunction

    assign w_multi   = (r_sel & (r_sel - NUM_CH'(1))) != '0;
    assign w_sel_idx = lowest_idx(r_sel);
    assign w_rem     = r_mask & ~(NUM_CH'(1) << r_ch);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_mask  <= '0;
            r_bit   <= '0;
            r_ch    <= '0;
`ifdef SER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (auto_start && auto_ch_mask != '0) begin
                        r_state <= SCAN;
                        r_mask  <= auto_ch_mask;
                        r_ch    <= lowest_idx(auto_ch_mask);
                        r_bit   <= '0;
                        r_sel   <= '0;
`ifdef SER_PARITY_EN
                        r_par   <= 1'b0;
`endif
                    end else begin
                        r_sel <= load_cnt_ser;
                    end
                end
                SCAN: begin
`ifdef SER_PARITY_EN
                    r_par <= r_par ^ raw_serial_out[r_ch];
`endif
                    if (r_bit == LAST_BIT) begin
                        r_bit  <= '0;
                        r_mask <= w_rem;
`ifdef SER_PARITY_EN
                        r_state <= PAR;
`else
                        if (w_rem == '0) r_state <= DONE;
                        else             r_ch    <= lowest_idx(w_rem);
`endif
                    end else begin
                        r_bit <= r_bit + BIT_W'(1);
                    end
                end
`ifdef SER_PARITY_EN
                // Mask bit was already cleared on the last data bit; pick the next frame here.
                PAR: begin
                    r_par <= 1'b0;
                    if (r_mask == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= SCAN;
                        r_ch    <= lowest_idx(r_mask);
                    end
                end
`endif
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        serial_out = wr_serial_out;
        active_ch  = '0;
        case (r_state)
            IDLE: begin
                if (w_multi) begin
                    serial_out = 1'b0;
                end else if (r_sel != '0) begin
                    serial_out = raw_serial_out[w_sel_idx];
                    active_ch  = w_sel_idx;
                end
            end
            SCAN: begin
                serial_out = raw_serial_out[r_ch];
                active_ch  = r_ch;
            end
`ifdef SER_PARITY_EN
            PAR: begin
                serial_out = r_par;
                active_ch  = r_ch;
            end
`endif
            default: ;
        endcase
    end

    assign busy        = (r_state != IDLE);
`ifdef SER_PARITY_EN
    assign frame_valid = (r_state == SCAN) || (r_state == PAR);
`else
    assign frame_valid = (r_state == SCAN);
`endif
    assign sel_err     = (r_state == IDLE) && w_multi;

endmodule

// File: tb/tb_serial_out_sequencer.sv
// Self-checking bench for serial_out_sequencer: a schedule-queue model checked every cycle,
// plus literal checks for latency, illegal select, scan ordering, reset and parity.
module tb_serial_out_sequencer;
    localparam int NUM_CH     = 8;
    localparam int FRAME_BITS = 12;
`ifdef SER_PARITY_EN
    localparam int FLEN = FRAME_BITS + 1;
`else
    localparam int FLEN = FRAME_BITS;
`endif

    logic       sclk = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] raw  = '0;
    logic       wr   = 1'b0;
    logic [7:0] lcs  = '0;
    logic       as   = 1'b0;
    logic [7:0] mask = '0;
    logic       so, busy, fv, se;
    logic [2:0] ach;

    always #5 sclk = ~sclk;

    serial_out_sequencer #(.NUM_CH(NUM_CH), .FRAME_BITS(FRAME_BITS)) dut (
        .sclk(sclk), .rst(rst), .raw_serial_out(raw), .wr_serial_out(wr),
        .load_cnt_ser(lcs), .auto_start(as), .auto_ch_mask(mask),
        .serial_out(so), .busy(busy), .frame_valid(fv), .active_ch(ach), .sel_err(se)
    );

    // kind: 0 = data bit, 1 = parity bit, 2 = done cycle
    typedef struct { int kind; int ch; int bitn; } ev_t;
    ev_t        m_q[$];
    ev_t        m_e;
    logic [7:0] m_sel;
    logic       m_par;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge sclk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_sel = '0;
            m_par = 1'b0;
        end else if (m_q.size() != 0) begin
            m_e = m_q.pop_front();
            if (m_e.kind == 0)      m_par = m_par ^ raw[m_e.ch];
            else if (m_e.kind == 1) m_par = 1'b0;
        end else if (as && mask != 0) begin
            m_sel = '0;
            m_par = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (mask[c]) begin
                    for (int b = 0; b < FRAME_BITS; b++) begin
                        m_e = '{kind: 0, ch: c, bitn: b};
                        m_q.push_back(m_e);
                    end
`ifdef SER_PARITY_EN
                    m_e = '{kind: 1, ch: c, bitn: FRAME_BITS};
                    m_q.push_back(m_e);
`endif
                end
            end
            m_e = '{kind: 2, ch: 0, bitn: 0};
            m_q.push_back(m_e);
        end else begin
            m_sel = lcs;
        end
    end

    logic       e_so, e_busy, e_fv, e_se;
    logic [2:0] e_ach;
    ev_t        h;
    always @(negedge sclk) begin
        e_so = wr; e_busy = 1'b0; e_fv = 1'b0; e_se = 1'b0; e_ach = '0;
        if (m_q.size() == 0) begin
            if ($countones(m_sel) == 1) begin
                for (int i = 0; i < NUM_CH; i++)
                    if (m_sel[i]) begin e_so = raw[i]; e_ach = 3'(i); end
            end else if ($countones(m_sel) > 1) begin
                e_so = 1'b0;
                e_se = 1'b1;
            end
        end else begin
            h = m_q[0];
            e_busy = 1'b1;
            if (h.kind == 0)      begin e_fv = 1'b1; e_so = raw[h.ch]; e_ach = 3'(h.ch); end
            else if (h.kind == 1) begin e_fv = 1'b1; e_so = m_par;      e_ach = 3'(h.ch); end
        end
        check("serial_out", so, e_so);
        check("busy", busy, e_busy);
        check("frame_valid", fv, e_fv);
        check("active_ch", ach, e_ach);
        check("sel_err", se, e_se);
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    int         fvn, donen, k, seq_ok, ended, hit;
    int         exp_ch;
    logic [11:0] pat;

    initial begin
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        check("rst_busy", busy, 0);
        check("rst_fv", fv, 0);
        check("rst_ach", ach, 0);
        check("rst_se", se, 0);
        step(); rst = 1'b0;

        // manual, select zero: output tracks wr_serial_out
        for (int i = 0; i < 6; i++) begin
            step(); wr = ~wr; raw = 8'($urandom);
            @(negedge sclk);
            check("wr_track", so, wr);
        end

        // one-hot select latency
        step(); wr = 1'b0; raw = 8'h04; lcs = 8'h04;
        @(negedge sclk);
        check("onehot_early_so", so, 0);
        check("onehot_early_ach", ach, 0);
        step();
        @(negedge sclk);
        check("onehot_so", so, 1);
        check("onehot_ach", ach, 2);

        // illegal select then recovery
        step(); raw = 8'hFF; lcs = 8'h03;
        step(); lcs = 8'h01;
        @(negedge sclk);
        check("multi_so", so, 0);
        check("multi_se", se, 1);
        step();
        @(negedge sclk);
        check("recover_se", se, 0);
        check("recover_so", so, 1);

        // random manual traffic
        for (int i = 0; i < 40; i++) begin
            step();
            raw = 8'($urandom); wr = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       lcs = '0;
                3:       lcs = 8'($urandom);
                default: lcs = 8'(1 << $urandom_range(0, 7));
            endcase
        end

        // auto scan of channels 0, 2, 7 with noise on ignored inputs
        step(); as = 1'b1; mask = 8'b1000_0101;
        fvn = 0; donen = 0; k = 0; seq_ok = 1; ended = 0;
        for (int t = 0; t < 3 * FLEN + 10 && ended == 0; t++) begin
            step();
            as = 1'($urandom); lcs = 8'($urandom); raw = 8'($urandom);
            wr = 1'($urandom); mask = 8'($urandom);
            @(negedge sclk);
            if (fv) begin
                exp_ch = (k < FLEN) ? 0 : (k < 2 * FLEN) ? 2 : 7;
                if (ach != 3'(exp_ch)) seq_ok = 0;
                k++;
                fvn++;
            end
            if (busy && !fv) donen++;
            if (!busy) ended = 1;
        end
        as = 1'b0; lcs = '0;
        check("scan_fv_cycles", fvn, 3 * FLEN);
        check("scan_done_cycles", donen, 1);
        check("scan_order", seq_ok, 1);
        check("scan_ended", ended, 1);

        // zero mask is ignored
        step(); as = 1'b1; mask = '0;
        step(); as = 1'b0;
        @(negedge sclk);
        check("zero_mask_busy", busy, 0);

        // mid-scan reset at bit 5 of channel 3
        step(); as = 1'b1; mask = 8'hFF;
        hit = 0;
        for (int t = 0; t < 8 * FLEN && hit == 0; t++) begin
            step(); as = 1'b0; raw = 8'($urandom);
            if (m_q.size() != 0 && m_q[0].kind == 0 && m_q[0].ch == 3 && m_q[0].bitn == 5) hit = 1;
        end
        check("midscan_reached", hit, 1);
        wr = 1'b1; rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_fv", fv, 0);
        check("abort_ach", ach, 0);
        check("abort_se", se, 0);
        check("abort_so", so, 1);
        step(); rst = 1'b0;
        step(); as = 1'b1; mask = 8'hFF;
        step(); as = 1'b0;
        @(negedge sclk);
        check("restart_fv", fv, 1);
        check("restart_ach", ach, 0);
        ended = 0;
        for (int t = 0; t < 8 * FLEN + 10 && ended == 0; t++) begin
            step(); raw = 8'($urandom);
            @(negedge sclk);
            if (!busy) ended = 1;
        end
        check("restart_ended", ended, 1);

        // channel 0 frame with five ones
        pat = 12'b1100_0001_0101;
        step(); as = 1'b1; mask = 8'h01;
        for (int b = 0; b < FRAME_BITS; b++) begin
            step(); as = 1'b0; raw = {7'($urandom), pat[b]};
        end
        step(); raw = 8'($urandom);
        @(negedge sclk);
`ifdef SER_PARITY_EN
        check("parity_so", so, 1);
        check("parity_fv", fv, 1);
        step();
        @(negedge sclk);
`endif
        check("frame_done_busy", busy, 1);
        check("frame_done_fv", fv, 0);

        // random scans
        for (int n = 0; n < 4; n++) begin
            step(); as = 1'b1; mask = 8'($urandom_range(1, 255));
            ended = 0;
            for (int t = 0; t < 8 * FLEN + 10 && ended == 0; t++) begin
                step();
                as = 1'($urandom); lcs = 8'($urandom); raw = 8'($urandom);
                wr = 1'($urandom); mask = 8'($urandom);
                @(negedge sclk);
                if (!busy) ended = 1;
            end
            as = 1'b0;
            check("rand_scan_ended", ended, 1);
        end

        step(); step();
        @(negedge sclk);
        check("final_idle", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
